button_conditioner: RTL



---
 rtl/btn_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 141 ++++++++++++++
 rtl/button_conditioner.sv | 50 +++++
 3 files changed

// File: rtl/btn_pkg.sv
// ============================================================================
// Module      : btn_pkg
// Description : Shared encodings and constants for the button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        S_REL    = 2'b00,
        S_WPRESS = 2'b01,
        S_PRESS  = 2'b10,
        S_WREL   = 2'b11
    } btn_state_t;

    // Board channel assignment consumed by the controller
    localparam int BTN_RESET = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;

    // 10 ms of stability at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : One button bit: 2-FF synchronizer, debounce FSM with stability
//               counter, registered level and press pulse.
//               Optional macro BTN_RELEASE_PULSE_EN adds a release pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_hw,
    input  logic btn_in,
    output logic level,
    output logic pulse
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic release_pulse
`endif
);

    localparam int             CW             = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  c_count_target = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  c_count_one    = CW'(1);
    localparam logic [CW-1:0]  c_count_zero   = '0;

    logic [1:0]    r_sync_q,    w_sync_d;
    btn_state_t    r_state_q,   w_state_d;
    logic [CW-1:0] r_count_q,   w_count_d;
    logic          r_level_q,   w_level_d;
    logic          r_pulse_q,   w_pulse_d;
    logic          r_release_q, w_release_d;
    logic [CW-1:0] w_count_inc;
    logic          w_seen;

    assign w_sync_d    = {r_sync_q[0], btn_in};
    assign w_seen      = r_sync_q[1];
    // Counter is cleared on every acceptance, so it stays below the target here
    assign w_count_inc = r_count_q + c_count_one;

    always_comb begin
        w_state_d   = r_state_q;
        w_count_d   = r_count_q;
        w_level_d   = r_level_q;
        w_pulse_d   = 1'b0;
        w_release_d = 1'b0;
        case (r_state_q)
            S_REL: begin
                if (w_seen) begin
                    if (c_count_one == c_count_target) begin
                        w_state_d = S_PRESS;
                        w_level_d = 1'b1;
                        w_pulse_d = 1'b1;
                        w_count_d = c_count_zero;
                    end else begin
                        w_state_d = S_WPRESS;
                        w_count_d = c_count_one;
                    end
                end
            end
            S_WPRESS: begin
                if (!w_seen) begin
                    w_state_d = S_REL;
                    w_count_d = c_count_zero;
                end else if (w_count_inc == c_count_target) begin
                    w_state_d = S_PRESS;
                    w_level_d = 1'b1;
                    w_pulse_d = 1'b1;
                    w_count_d = c_count_zero;
                end else begin
                    w_count_d = w_count_inc;
                end
            end
            S_PRESS: begin
                if (!w_seen) begin
                    if (c_count_one == c_count_target) begin
                        w_state_d   = S_REL;
                        w_level_d   = 1'b0;
                        w_release_d = 1'b1;
                        w_count_d   = c_count_zero;
                    end else begin
                        w_state_d = S_WREL;
                        w_count_d = c_count_one;
                    end
                end
            end
            S_WREL: begin
                if (w_seen) begin
                    w_state_d = S_PRESS;
                    w_count_d = c_count_zero;
                end else if (w_count_inc == c_count_target) begin
                    w_state_d   = S_REL;
                    w_level_d   = 1'b0;
                    w_release_d = 1'b1;
                    w_count_d   = c_count_zero;
                end else begin
                    w_count_d = w_count_inc;
                end
            end
            default: begin
                w_state_d = S_REL;
                w_count_d = c_count_zero;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_hw) begin
            r_sync_q    <= 2'b00;
            r_state_q   <= S_REL;
            r_count_q   <= c_count_zero;
            r_level_q   <= 1'b0;
            r_pulse_q   <= 1'b0;
            r_release_q <= 1'b0;
        end else begin
            r_sync_q    <= w_sync_d;
            r_state_q   <= w_state_d;
            r_count_q   <= w_count_d;
            r_level_q   <= w_level_d;
            r_pulse_q   <= w_pulse_d;
            r_release_q <= w_release_d;
        end
    end

    assign level = r_level_q;
    assign pulse = r_pulse_q;

`ifdef BTN_RELEASE_PULSE_EN
    assign release_pulse = r_release_q;
`else
    logic w_release_unused;
    assign w_release_unused = r_release_q;
`endif

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : Debounces N_BTN raw push-buttons into levels and press pulses.
//               Optional macro BTN_RELEASE_PULSE_EN adds output btn_release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_hw,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic [N_BTN-1:0] btn_release
`endif
);

    logic [N_BTN-1:0] w_btn_pressed;

    // Polarity fixed ahead of the synchronizer so every channel sees 1 = pressed
    assign w_btn_pressed = ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk           (clk),
            .rst_hw        (rst_hw),
            .btn_in        (w_btn_pressed[g]),
            .level         (btn_level[g]),
            .pulse         (btn_pulse[g])
`ifdef BTN_RELEASE_PULSE_EN
            ,
            .release_pulse (btn_release[g])
`endif
        );
    end

endmodule

`default_nettype wire
